// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencing FSM for the single-cycle core.
//               Computes the next PC from the decoded flow op (NEXT, BR, JMP,
//               CALL, RET, HALT), keeps a small return-address stack and
//               counts retired instructions with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_W     = 8,
    parameter int DEPTH    = 4,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stall,
    input  logic [2:0]              op,
    input  logic                    cond,
    input  logic [PC_W-1:0]         target,
    output logic [PC_W-1:0]         pc,
    output logic                    running,
    output logic                    halted,
    output logic                    fault,
    output logic [$clog2(DEPTH):0]  depth,
    output logic [CNT_W-1:0]        retired
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              running_q, halted_q, fault_q;
    logic              push_en;
    logic [PC_W-1:0]   stack_q [DEPTH];

    logic [PC_W-1:0]   pc_inc;
    logic [CNT_W-1:0]  retired_inc;

    // Modulo-2^PC_W increment; a relative branch is a plain add because the
    // offset already has PC_W bits in two's complement.
    assign pc_inc      = pc_q + PC_W'(1);
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    // Next-state logic: restart, per-op PC update, stack bookkeeping, faults.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        depth_d   = depth_q;
        retired_d = retired_q;
        push_en   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    if (start) begin
                        state_d   = S_RUN;
                        pc_d      = PC_W'(START_PC);
                        depth_d   = '0;
                        retired_d = '0;
                    end else begin
                        retired_d = retired_inc;
                        case (op)
                            OP_BR:   pc_d = cond ? (pc_q + target) : pc_inc;
                            OP_JMP:  pc_d = target;
                            OP_CALL: begin
                                if (depth_q == DW'(DEPTH)) begin
                                    state_d   = S_FAULT;
                                    retired_d = retired_q;
                                end else begin
                                    push_en = 1'b1;
                                    pc_d    = target;
                                    depth_d = depth_q + DW'(1);
                                end
                            end
                            OP_RET: begin
                                if (depth_q == '0) begin
                                    state_d   = S_FAULT;
                                    retired_d = retired_q;
                                end else begin
                                    pc_d    = stack_q[AW'(depth_q - DW'(1))];
                                    depth_d = depth_q - DW'(1);
                                end
                            end
                            OP_HALT: state_d = S_HALTED;
                            default: pc_d = pc_inc;
                        endcase
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = PC_W'(START_PC);
                    depth_d   = '0;
                    retired_d = '0;
                end
            end
        endcase
    end

    // Control state, PC, depth, counter and registered status decodes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_W'(START_PC);
            depth_q   <= '0;
            retired_q <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            depth_q   <= depth_d;
            retired_q <= retired_d;
            running_q <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALTED);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    // Return-address storage; contents are don't-care after reset, depth is
    // the only pointer so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[AW'(depth_q)] <= pc_inc;
        end
    end

    assign pc      = pc_q;
    assign depth   = depth_q;
    assign retired = retired_q;
    assign running = running_q;
    assign halted  = halted_q;
    assign fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Directed steps followed
//               by random ops, all checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W   = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 6;
    localparam int MOD    = 1 << PC_W;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic [2:0]        op = 3'd0;
    logic              cond = 1'b0;
    logic [PC_W-1:0]   target = '0;
    logic [PC_W-1:0]   pc;
    logic              running, halted, fault;
    logic [2:0]        depth;
    logic [CNT_W-1:0]  retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    string m_mode;
    int    m_pc;
    int    m_ret;
    int    m_stack[$];

    pc_sequencer #(
        .PC_W(PC_W), .DEPTH(DEPTH), .START_PC(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .op(op),
        .cond(cond), .target(target), .pc(pc), .running(running),
        .halted(halted), .fault(fault), .depth(depth), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},      int'(pc),      m_pc);
        check({tag, ".depth"},   int'(depth),   m_stack.size());
        check({tag, ".retired"}, int'(retired), m_ret);
        check({tag, ".running"}, int'(running), int'(m_mode == "RUN"));
        check({tag, ".halted"},  int'(halted),  int'(m_mode == "HALTED"));
        check({tag, ".fault"},   int'(fault),   int'(m_mode == "FAULT"));
    endtask

    task automatic model_reset();
        m_mode = "IDLE";
        m_pc   = 0;
        m_ret  = 0;
        m_stack.delete();
    endtask

    task automatic model_restart();
        m_mode = "RUN";
        m_pc   = 0;
        m_ret  = 0;
        m_stack.delete();
    endtask

    task automatic retire();
        if (m_ret < CNTMAX) m_ret++;
    endtask

    // One clock of architectural behaviour, straight from the op table.
    task automatic model_step(input bit st, input bit sl, input int o,
                              input bit c, input int t);
        int off;
        if (m_mode != "RUN") begin
            if (st) model_restart();
        end else if (sl) begin
            // frozen
        end else if (st) begin
            model_restart();
        end else begin
            case (o)
                1: begin
                    off = (t >= MOD / 2) ? t - MOD : t;
                    m_pc = c ? ((m_pc + off) % MOD + MOD) % MOD : (m_pc + 1) % MOD;
                    retire();
                end
                2: begin m_pc = t; retire(); end
                3: begin
                    if (m_stack.size() == DEPTH) m_mode = "FAULT";
                    else begin
                        m_stack.push_back((m_pc + 1) % MOD);
                        m_pc = t;
                        retire();
                    end
                end
                4: begin
                    if (m_stack.size() == 0) m_mode = "FAULT";
                    else begin
                        m_pc = m_stack.pop_back();
                        retire();
                    end
                end
                5: begin m_mode = "HALTED"; retire(); end
                default: begin m_pc = (m_pc + 1) % MOD; retire(); end
            endcase
        end
    endtask

    task automatic step(input string tag, input bit st, input bit sl,
                        input int o, input bit c, input int t);
        @(negedge clk);
        start  = st;
        stall  = sl;
        op     = 3'(o);
        cond   = c;
        target = PC_W'(t);
        @(posedge clk);
        model_step(st, sl, o, c, t);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) reset = 1'b1;

        // IDLE ignores ops
        step("idle_op", 0, 0, 2, 0, 8'h77);
        step("start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("next", 0, 0, 0, 0, 0);
        check("plan.pc5", int'(pc), 5);
        check("plan.ret5", int'(retired), 5);

        // Branches and wrap
        step("br_fwd", 0, 0, 1, 1, 8'h04);
        check("plan.pc9", int'(pc), 9);
        step("br_back", 0, 0, 1, 1, 8'hFC);
        check("plan.pc5b", int'(pc), 5);
        step("br_nt", 0, 0, 1, 0, 8'h40);
        step("jmp_ff", 0, 0, 2, 0, 8'hFF);
        step("wrap", 0, 0, 0, 0, 0);
        check("plan.wrap", int'(pc), 0);

        // Nested calls
        step("restart", 1, 0, 3, 0, 8'h10);
        step("n1", 0, 0, 0, 0, 0);
        step("n2", 0, 0, 0, 0, 0);
        step("call40", 0, 0, 3, 0, 8'h40);
        step("call80", 0, 0, 3, 0, 8'h80);
        check("plan.depth2", int'(depth), 2);
        step("ret1", 0, 0, 4, 0, 0);
        check("plan.ret41", int'(pc), 8'h41);
        step("ret2", 0, 0, 4, 0, 0);
        check("plan.ret3", int'(pc), 3);

        // Stack overflow / underflow faults
        for (int i = 0; i < 4; i++) step("fill", 0, 0, 3, 0, 16 * (i + 1));
        step("overflow", 0, 0, 3, 0, 8'h99);
        check("plan.ovf_fault", int'(fault), 1);
        step("fault_ignores", 0, 0, 0, 0, 0);
        step("fault_start", 1, 0, 0, 0, 0);
        step("underflow", 0, 0, 4, 0, 0);
        check("plan.unf_fault", int'(fault), 1);

        // Stall, start-under-stall, halt
        step("start2", 1, 0, 0, 0, 0);
        step("n3", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", (i == 1), 1, 2, 0, 8'h20);
        step("jmp20", 0, 0, 2, 0, 8'h20);
        check("plan.pc20", int'(pc), 8'h20);
        step("run_restart", 1, 0, 2, 0, 8'h55);
        step("halt", 0, 0, 5, 0, 0);
        step("halt_ign", 0, 0, 3, 0, 8'h11);
        step("halt_ign2", 0, 0, 0, 0, 0);

        // CALL at 255 pushes 0
        step("start3", 1, 0, 0, 0, 0);
        step("jmp_ff2", 0, 0, 2, 0, 8'hFF);
        step("call_ff", 0, 0, 3, 0, 8'h10);
        step("ret_wrap", 0, 0, 4, 0, 0);
        check("plan.ret0", int'(pc), 0);

        // Counter saturation
        for (int i = 0; i < CNTMAX + 6; i++) step("sat", 0, 0, 7, 0, 0);
        check("plan.sat", int'(retired), CNTMAX);

        // Async reset between edges, mid-stall
        step("start4", 1, 0, 0, 0, 0);
        step("c10", 0, 0, 3, 0, 8'h10);
        step("c33", 0, 0, 3, 0, 8'h33);
        step("stall_pre", 0, 1, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk) reset = 1'b1;
        step("post_rst", 0, 0, 0, 0, 0);

        // Random ops
        for (int i = 0; i < 800; i++) begin
            automatic int o  = $urandom_range(0, 7);
            automatic bit st = ($urandom_range(0, 99) < 3);
            automatic bit sl = ($urandom_range(0, 99) < 15);
            automatic bit c  = 1'($urandom);
            automatic int t  = $urandom_range(0, MOD - 1);
            if (m_mode != "RUN" && $urandom_range(0, 3) == 0) st = 1'b1;
            step("rand", st, sl, o, c, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
